// File: rtl/uart_rx_framer.sv
// ============================================================================
// Module   : uart_rx_framer
// Purpose  : Oversampled UART receiver with a valid/ready output register.
//            Build with UART_RX_PARITY_EN for 8E1 frames; 8N1 otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_12p0,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             overrun_q;
`ifdef UART_RX_PARITY_EN
  logic             perr_q;
  logic             par_bad_q;
`endif

  logic w_fall;
  assign w_fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk_12p0) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx_in;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      // A reload in STOP below overrides this clear in the same cycle.
      if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (w_fall) begin
            state_q   <= START;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        START: begin
          if (cnt_q == c_half_last) begin
            cnt_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == c_bit_last) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == c_bit_last) begin
            cnt_q     <= '0;
            par_bad_q <= ^{shift_q, rx_s_q};
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_q == c_bit_last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_s_q) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_q <= 1'b1;
`endif
            end else if (!valid_q || data_ready) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
